// File: rtl/cordic_pkg.sv
// Shared types and helpers for the linear-vectoring CORDIC divider family.
// Holds the control-state encoding and the quotient saturation constants.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest positive quotient code for a qw-bit two's complement result (low qw bits valid).
    function automatic logic [63:0] qmax(input int qw);
        return (64'd1 << (qw - 1)) - 64'd1;
    endfunction

    // Most negative quotient code; its low qw bits are 1000..0.
    function automatic logic [63:0] qmin(input int qw);
        return ~qmax(qw);
    endfunction

endpackage

// File: rtl/cordic_lin_step.sv
// One combinational non-restoring iteration of the linear-vectoring CORDIC.
// Kept standalone so an unrolled pipeline can chain copies of it.
module cordic_lin_step #(
    parameter int RW = 18,
    parameter int QW = 16
) (
    input  logic signed [RW-1:0] r,
    input  logic signed [QW-1:0] z,
    input  logic signed [RW-1:0] ax,
    input  logic signed [QW-1:0] weight,
    output logic signed [RW-1:0] r_next,
    output logic signed [QW-1:0] z_next
);

    logic signed [RW-1:0] diff;

    // Pick the direction from the residual sign; doubling is a plain left shift, so nothing is truncated.
    always_comb begin
        if (r[RW-1] == 1'b0) begin
            diff   = r - ax;
            z_next = z + weight;
        end else begin
            diff   = r + ax;
            z_next = z - weight;
        end
        r_next = {diff[RW-2:0], 1'b0};
    end

endmodule

// File: rtl/cordic_div_hs.sv
// Sequential signed divider q = y/x in Q2.(QWIDTH-2) using linear-vectoring CORDIC,
// with valid/ready handshakes, saturation and divide-by-zero flags, and fixed latency.
module cordic_div_hs
    import cordic_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int QWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DWIDTH-1:0] x_i,
    input  logic signed [DWIDTH-1:0] y_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [QWIDTH-1:0] q_o,
    output logic                     sat_o,
    output logic                     dz_o,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int RW = DWIDTH + 2;
    localparam int CW = $clog2(QWIDTH);
    localparam logic [QWIDTH-1:0] Q_MAX    = QWIDTH'(qmax(QWIDTH));
    localparam logic [QWIDTH-1:0] Q_MIN    = QWIDTH'(qmin(QWIDTH));
    localparam logic [CW-1:0]     CNT_LAST = CW'(QWIDTH - 2);

    state_t state;
    logic   sx, sy, zx, ov, yz;
    logic   [CW-1:0] cnt;

    logic signed [RW-1:0]     ax, r, r_next;
    logic signed [RW-1:0]     xe, ye, ax_in, ay_in;
    logic signed [QWIDTH-1:0] z, z_next, wt, q_fix;

    // Operand magnitudes widened by two bits so -2^(DWIDTH-1) and 2|x| stay representable.
    always_comb begin
        xe = {{2{x_i[DWIDTH-1]}}, x_i};
        ye = {{2{y_i[DWIDTH-1]}}, y_i};
        if (x_i[DWIDTH-1]) begin
            ax_in = -xe;
        end else begin
            ax_in = xe;
        end
        if (y_i[DWIDTH-1]) begin
            ay_in = -ye;
        end else begin
            ay_in = ye;
        end
    end

    // Weight of the current iteration: 2^(QWIDTH-2-cnt).
    always_comb begin
        wt = {{(QWIDTH-1){1'b0}}, 1'b1} << (CNT_LAST - cnt);
    end

    cordic_lin_step #(
        .RW (RW),
        .QW (QWIDTH)
    ) u_step (
        .r      (r),
        .z      (z),
        .ax     (ax),
        .weight (wt),
        .r_next (r_next),
        .z_next (z_next)
    );

    // Final quotient selection: divide-by-zero first, then overflow, then sign-restored z.
    always_comb begin
        if (zx) begin
            if (yz) begin
                q_fix = {QWIDTH{1'b0}};
            end else if (sy) begin
                q_fix = Q_MIN;
            end else begin
                q_fix = Q_MAX;
            end
        end else if (ov) begin
            if (sx ^ sy) begin
                q_fix = Q_MIN;
            end else begin
                q_fix = Q_MAX;
            end
        end else if (sx ^ sy) begin
            q_fix = -z;
        end else begin
            q_fix = z;
        end
    end

    // Operands are only taken while idle.
    always_comb begin
        if (state == IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Control FSM and datapath registers; CALC always runs its full length for fixed latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sx        <= 1'b0;
            sy        <= 1'b0;
            zx        <= 1'b0;
            ov        <= 1'b0;
            yz        <= 1'b0;
            ax        <= {RW{1'b0}};
            r         <= {RW{1'b0}};
            z         <= {QWIDTH{1'b0}};
            cnt       <= {CW{1'b0}};
            q_o       <= {QWIDTH{1'b0}};
            sat_o     <= 1'b0;
            dz_o      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sx    <= x_i[DWIDTH-1];
                        sy    <= y_i[DWIDTH-1];
                        zx    <= (x_i == {DWIDTH{1'b0}});
                        yz    <= (y_i == {DWIDTH{1'b0}});
                        ov    <= (ay_in >= (ax_in <<< 1));
                        ax    <= ax_in;
                        r     <= ay_in;
                        z     <= {QWIDTH{1'b0}};
                        cnt   <= {CW{1'b0}};
                        state <= CALC;
                    end
                end
                CALC: begin
                    r <= r_next;
                    z <= z_next;
                    if (cnt == CNT_LAST) begin
                        cnt   <= {CW{1'b0}};
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    q_o       <= q_fix;
                    sat_o     <= zx | ov;
                    dz_o      <= zx;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
